hyperspectral_hw_wrapped_mac_pipe: RTL and testbench
====================================================

HYPERSPECTRAL_HW_WRAPPED_MAC_PIPE -- requirements
Module: hyperspectral_hw_wrapped_mac_pipe

Interface
REQ-001 Parameter DIN0_WIDTH, default 19: width of signed operand din0.
REQ-002 Parameter DIN1_WIDTH, default 8: width of unsigned operand din1.
REQ-003 Parameter DOUT_WIDTH, default 19: width of signed result dout.
REQ-004 Parameter ACC_WIDTH, default 40: accumulator width; SHALL be >= DIN0_WIDTH+DIN1_WIDTH+1.
REQ-005 Parameter MUL_STAGES, default 3: multiplier pipeline depth; SHALL be >= 1.
REQ-006 Port clk  input  1: single clock; all logic on rising edge.
REQ-007 Port reset  input  1: synchronous, active-high reset.
REQ-008 Port ce  input  1: global clock enable; 0 freezes all state.
REQ-009 Port in_valid  input  1: input sample present.
REQ-010 Port in_ready  output  1: block accepts sample this cycle.
REQ-011 Port din0  input  DIN0_WIDTH: signed operand.
REQ-012 Port din1  input  DIN1_WIDTH: unsigned operand.
REQ-013 Port acc_en  input  1: 1 = sample joins running sum; 0 = plain multiply.
REQ-014 Port in_last  input  1: with acc_en=1, closes the sum (last band of pixel).
REQ-015 Port out_valid  output  1: dout/out_ovf valid.
REQ-016 Port out_ready  input  1: consumer accepts result.
REQ-017 Port dout  output  DOUT_WIDTH: signed, saturated result.
REQ-018 Port out_ovf  output  1: dout was saturated.

Function
REQ-019 Advance enable adv = ce AND NOT (out_valid AND NOT out_ready); in_ready SHALL equal adv.
REQ-020 A sample SHALL be accepted iff in_valid AND in_ready; acc_en and in_last travel with it as tags.
REQ-021 Product SHALL be din0 * signed({1'b0,din1}), full width DIN0_WIDTH+DIN1_WIDTH+1, no truncation inside the pipeline.
REQ-022 Operand register plus MUL_STAGES product stages SHALL shift, with per-stage valid bits, only when adv=1; bubbles carry valid=0.
REQ-023 Tail sample with acc_en=0: result = product; accumulator untouched; output register loaded.
REQ-024 Tail sample with acc_en=1, in_last=0: acc <= (first ? 0 : acc) + sign-extended product; first <= 0; no output.
REQ-025 Tail sample with acc_en=1, in_last=1: result = (first ? 0 : acc) + product; output loaded; acc <= 0; first <= 1.
REQ-026 Accumulator SHALL wrap modulo 2^ACC_WIDTH; wrap is not flagged.
REQ-027 Result SHALL be clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; out_ovf=1 iff clamping changed the value.
REQ-028 Latency accept -> out_valid SHALL be MUL_STAGES+2 adv cycles (5 at defaults) for plain and last samples.
REQ-029 out_valid SHALL stay 1 with dout/out_ovf stable until out_ready=1; drops next cycle unless a new result loads the same cycle.
REQ-030 Plain samples interleaved inside an open sum SHALL not disturb acc or first.
REQ-031 With ce=0, every register, including out_valid, SHALL hold; in_ready=0.
REQ-032 Results SHALL emerge in acceptance order; no sample lost or duplicated under any out_ready pattern.

Reset
REQ-033 On reset=1 at a clock edge (regardless of ce): all valid bits 0, out_valid 0, dout 0, out_ovf 0, acc 0, first 1.
REQ-034 Reset mid-operation SHALL discard in-flight samples and any partial sum; in_ready SHALL be 1 in the first cycle after reset if ce=1.

Verification
REQ-035 Plain: din0=-5, din1=200, acc_en=0, out_ready=1 -> out_valid 5 cycles later, dout=-1000, out_ovf=0.
REQ-036 Saturation: din0=262143, din1=255 -> dout=262143, out_ovf=1; din0=-262144, din1=255 -> dout=-262144, out_ovf=1.
REQ-037 Accumulate: din0=100,-50,25,10, din1=2, acc_en=1, in_last on 4th -> one out_valid pulse, dout=170; next sum starts from 0.
REQ-038 Backpressure: 8 back-to-back plain samples, out_ready low 5 cycles mid-stream -> in_ready low, 8 correct results in order.
REQ-039 ce: ce=0 for 3 cycles mid-stream -> all outputs frozen, results identical to ce=1 run shifted by 3 cycles.
REQ-040 Reset mid-sum: 2 accumulate samples, reset, then din0=7, din1=3, acc_en=1, in_last=1 -> dout=21.

Source files
------------

// File: rtl/hyperspectral_hw_wrapped_mac_pipe.sv
// Pipelined signed x unsigned multiplier with tagged running-sum accumulation,
// saturating output register and ready/valid flow control on both sides.
module hyperspectral_hw_wrapped_mac_pipe #(
   parameter int DIN0_WIDTH = 19,
   parameter int DIN1_WIDTH = 8,
   parameter int DOUT_WIDTH = 19,
   parameter int ACC_WIDTH  = 40,
   parameter int MUL_STAGES = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic        [DIN1_WIDTH-1:0] din1,
   input  logic                         acc_en,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         out_ovf
);

   localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   logic                         adv;

   logic                         op_vld_q, op_vld_d;
   logic                         op_acc_q, op_acc_d;
   logic                         op_last_q, op_last_d;
   logic signed [DIN0_WIDTH-1:0] op0_q, op0_d;
   logic        [DIN1_WIDTH-1:0] op1_q, op1_d;

   logic                         pv_q    [MUL_STAGES];
   logic                         pv_d    [MUL_STAGES];
   logic                         pacc_q  [MUL_STAGES];
   logic                         pacc_d  [MUL_STAGES];
   logic                         plast_q [MUL_STAGES];
   logic                         plast_d [MUL_STAGES];
   logic signed [PW-1:0]         prod_q  [MUL_STAGES];
   logic signed [PW-1:0]         prod_d  [MUL_STAGES];

   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                         first_q, first_d;
   logic                         out_valid_q, out_valid_d;
   logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                         ovf_q, ovf_d;

   logic signed [PW-1:0]         a_ext, b_ext, mul;
   logic signed [ACC_WIDTH-1:0]  p_ext, base, sum, res;
   logic signed [DOUT_WIDTH-1:0] sat_val;
   logic                         sat_ovf;
   logic                         tail_vld, tail_acc, tail_last;

   always_comb begin
      adv      = ce & ~(out_valid_q & ~out_ready);
      in_ready = adv;

      // din1 is zero-extended so the signed multiply treats it as unsigned
      a_ext = PW'(op0_q);
      b_ext = PW'(op1_q);
      mul   = a_ext * b_ext;

      tail_vld  = pv_q[MUL_STAGES-1];
      tail_acc  = pacc_q[MUL_STAGES-1];
      tail_last = plast_q[MUL_STAGES-1];
      p_ext     = ACC_WIDTH'(prod_q[MUL_STAGES-1]);
      base      = first_q ? '0 : acc_q;
      sum       = base + p_ext;
      res       = tail_acc ? sum : p_ext;

      sat_ovf = 1'b1;
      if (res > SAT_MAX)
         sat_val = SAT_MAX[DOUT_WIDTH-1:0];
      else if (res < SAT_MIN)
         sat_val = SAT_MIN[DOUT_WIDTH-1:0];
      else begin
         sat_val = res[DOUT_WIDTH-1:0];
         sat_ovf = 1'b0;
      end

      op_vld_d    = op_vld_q;
      op_acc_d    = op_acc_q;
      op_last_d   = op_last_q;
      op0_d       = op0_q;
      op1_d       = op1_q;
      pv_d        = pv_q;
      pacc_d      = pacc_q;
      plast_d     = plast_q;
      prod_d      = prod_q;
      acc_d       = acc_q;
      first_d     = first_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;

      if (adv) begin
         op_vld_d   = in_valid;
         op_acc_d   = acc_en;
         op_last_d  = in_last;
         op0_d      = din0;
         op1_d      = din1;
         pv_d[0]    = op_vld_q;
         pacc_d[0]  = op_acc_q;
         plast_d[0] = op_last_q;
         prod_d[0]  = mul;
         for (int i = 1; i < MUL_STAGES; i++) begin
            pv_d[i]    = pv_q[i-1];
            pacc_d[i]  = pacc_q[i-1];
            plast_d[i] = plast_q[i-1];
            prod_d[i]  = prod_q[i-1];
         end

         // adv=1 means any pending result is consumed this cycle
         out_valid_d = 1'b0;
         if (tail_vld) begin
            if (tail_acc && !tail_last) begin
               acc_d   = sum;
               first_d = 1'b0;
            end else begin
               out_valid_d = 1'b1;
               dout_d      = sat_val;
               ovf_d       = sat_ovf;
               if (tail_acc) begin
                  acc_d   = '0;
                  first_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_vld_q  <= 1'b0;
         op_acc_q  <= 1'b0;
         op_last_q <= 1'b0;
         op0_q     <= '0;
         op1_q     <= '0;
         for (int i = 0; i < MUL_STAGES; i++) begin
            pv_q[i]    <= 1'b0;
            pacc_q[i]  <= 1'b0;
            plast_q[i] <= 1'b0;
            prod_q[i]  <= '0;
         end
         acc_q       <= '0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         op_vld_q    <= op_vld_d;
         op_acc_q    <= op_acc_d;
         op_last_q   <= op_last_d;
         op0_q       <= op0_d;
         op1_q       <= op1_d;
         pv_q        <= pv_d;
         pacc_q      <= pacc_d;
         plast_q     <= plast_d;
         prod_q      <= prod_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_hyperspectral_hw_wrapped_mac_pipe.sv
// Directed bench for the MAC pipe: latency, saturation, sums, backpressure,
// clock-enable freeze and reset mid-sum, with hand-computed expectations.
module tb_hyperspectral_hw_wrapped_mac_pipe;

   localparam int D0 = 19;
   localparam int D1 = 8;
   localparam int DO = 19;

   logic                 clk = 1'b0;
   logic                 reset, ce, in_valid, in_ready, acc_en, in_last;
   logic                 out_valid, out_ready, out_ovf;
   logic signed [D0-1:0] din0;
   logic        [D1-1:0] din1;
   logic signed [DO-1:0] dout;

   hyperspectral_hw_wrapped_mac_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din0      (din0),
      .din1      (din1),
      .acc_en    (acc_en),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int stall_lo = -100;
   int ce_lo = -100;
   bit saw_stall;
   int q_d[$];
   int q_o[$];
   int q_t[$];
   int bt[6];
   int t0, lat;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply_ctl();
      ce        = !(cyc_n >= ce_lo && cyc_n < ce_lo + 3);
      out_ready = !(cyc_n >= stall_lo && cyc_n < stall_lo + 5);
   endtask

   // one clock cycle: capture handshakes, then verify freeze across a ce=0 edge
   task automatic cyc();
      logic pce, pv;
      logic signed [DO-1:0] pd;
      #1;
      if (!ce) chk("ce_in_ready", in_ready, 0);
      if (in_valid && !in_ready && ce) saw_stall = 1'b1;
      if (out_valid && out_ready && ce) begin
         q_d.push_back(int'(dout));
         q_o.push_back(int'(out_ovf));
         q_t.push_back(cyc_n);
      end
      pce = ce; pv = out_valid; pd = dout;
      @(negedge clk);
      cyc_n++;
      if (!pce) begin
         chk("ce_hold_vld", out_valid, pv);
         chk("ce_hold_dout", dout, pd);
      end
      apply_ctl();
   endtask

   task automatic send(input int d0, input int d1, input bit ae, input bit il);
      int guard = 0;
      din0 = D0'(d0); din1 = D1'(d1); acc_en = ae; in_last = il; in_valid = 1'b1;
      #1;
      while (!in_ready && guard < 50) begin
         cyc();
         #1;
         guard++;
      end
      chk("send_accept_bound", guard < 50, 1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) cyc();
   endtask

   task automatic exp_res(input string tag, input int d, input int o);
      chk({tag, "_present"}, q_d.size() > 0, 1);
      if (q_d.size() > 0) begin
         chk({tag, "_dout"}, q_d.pop_front(), d);
         chk({tag, "_ovf"}, q_o.pop_front(), o);
         void'(q_t.pop_front());
      end
   endtask

   task automatic clr_q();
      q_d.delete(); q_o.delete(); q_t.delete();
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      din0 = '0; din1 = '0; acc_en = 1'b0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ovf", out_ovf, 0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      apply_ctl();

      // plain multiply and its latency
      send(-5, 200, 0, 0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         cyc();
         lat++;
      end
      chk("plain_latency", lat, 5);
      chk("plain_dout", dout, -1000);
      chk("plain_ovf", out_ovf, 0);
      cyc();
      chk("plain_drop", out_valid, 0);
      clr_q();

      // saturation both ways
      send(262143, 255, 0, 0);
      send(-262144, 255, 0, 0);
      drain(8);
      exp_res("sat_pos", 262143, 1);
      exp_res("sat_neg", -262144, 1);

      // running sum, next sum from zero, plain interleaved, saturated sum
      send(100, 2, 1, 0);
      send(-50, 2, 1, 0);
      send(25, 2, 1, 0);
      send(10, 2, 1, 1);
      drain(8);
      chk("acc_pulses", q_d.size(), 1);
      exp_res("acc_sum", 170, 0);
      send(3, 4, 1, 1);
      drain(8);
      exp_res("acc_restart", 12, 0);
      send(10, 1, 1, 0);
      send(7, 7, 0, 0);
      send(5, 1, 1, 1);
      drain(8);
      exp_res("interleave_plain", 49, 0);
      exp_res("interleave_sum", 15, 0);
      send(262143, 255, 1, 0);
      send(262143, 255, 1, 0);
      send(0, 0, 1, 1);
      drain(8);
      exp_res("acc_sat", 262143, 1);
      chk("acc_no_extra", q_d.size(), 0);

      // backpressure: out_ready low 5 cycles mid-stream
      clr_q();
      saw_stall = 1'b0;
      stall_lo = cyc_n + 6;
      for (int i = 0; i < 8; i++) send(1000 * i - 3500, 3 * i + 1, 0, 0);
      drain(20);
      stall_lo = -100;
      chk("bp_in_ready_low", saw_stall, 1);
      chk("bp_count", q_d.size(), 8);
      for (int i = 0; i < 8; i++) exp_res("bp", (1000 * i - 3500) * (3 * i + 1), 0);

      // ce freeze: baseline run, then identical run with a 3-cycle ce=0 gap
      clr_q();
      t0 = cyc_n;
      for (int i = 0; i < 6; i++) send(-2000 * i + 77, 5 + i, 0, 0);
      drain(15);
      chk("ce_base_count", q_t.size(), 6);
      if (q_t.size() == 6) for (int i = 0; i < 6; i++) bt[i] = q_t[i] - t0;
      chk("ce_base_last_t", bt[5], 10);
      for (int i = 0; i < 6; i++) exp_res("ce_base", (-2000 * i + 77) * (5 + i), 0);
      clr_q();
      t0 = cyc_n;
      ce_lo = t0 + 7;
      for (int i = 0; i < 6; i++) send(-2000 * i + 77, 5 + i, 0, 0);
      drain(15);
      ce_lo = -100;
      chk("ce_run_count", q_t.size(), 6);
      if (q_t.size() == 6) chk("ce_shift_last_t", q_t[5] - t0, bt[5] + 3);
      for (int i = 0; i < 6; i++) exp_res("ce_run", (-2000 * i + 77) * (5 + i), 0);

      // reset in the middle of an open sum
      clr_q();
      send(50, 2, 1, 0);
      send(60, 2, 1, 0);
      drain(6);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_valid", out_valid, 0);
      @(negedge clk);
      apply_ctl();
      send(7, 3, 1, 1);
      drain(8);
      exp_res("rst_mid_sum", 21, 0);
      chk("rst_mid_no_extra", q_d.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
